// File: rtl/fb_pkg.sv
// fb_pkg: shared AXI3 read constants and reader FSM state encoding
// Holds the burst geometry (16 beats x 4 bytes, INCR, cache 0011) used by fb_reader.
package fb_pkg;
  localparam int BURST_WORDS = 16;
  localparam logic [31:0] BURST_BYTES = 32'd64;
  localparam logic [3:0] AXI_LEN = 4'd15;
  localparam logic [2:0] AXI_SIZE = 3'b010;
  localparam logic [1:0] AXI_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE = 4'b0011;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
endpackage

// File: rtl/fb_reader_if.sv
// fb_reader_if: AXI3 read-address and read-data channels between fb_reader and the fpga_to_hps port
// master: reader side (drives ar*, rready); slave: memory side (drives arready, r*).
interface fb_reader_if;
  logic arvalid;
  logic arready;
  logic [7:0] arid;
  logic [31:0] araddr;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [1:0] arlock;
  logic rvalid;
  logic rready;
  logic [7:0] rid;
  logic [1:0] rresp;
  logic [31:0] rdata;
  logic rlast;
  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, rready,
    input arready, rvalid, rid, rresp, rdata, rlast
  );
  modport slave (
    input arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, rready,
    output arready, rvalid, rid, rresp, rdata, rlast
  );
endinterface

// File: rtl/fb_fifo.sv
// fb_fifo: synchronous first-word-fall-through 32-bit FIFO with occupancy count
// Ports: clk/rst, push+wdata (write), pop (read ack), rdata+valid (head word), count (occupancy).
module fb_fifo #(
  parameter int DEPTH = 64
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic [31:0] wdata,
  input logic pop,
  output logic [31:0] rdata,
  output logic valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign do_pop = pop & valid;
  // a pop in the same cycle frees the slot a full FIFO is being written into
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fb_reader.sv
// fb_reader: frame-buffer reader issuing 16-beat AXI3 INCR bursts into a pixel FIFO
// Ports: clk/rst, start+base_addr+frame_words (frame request), busy/done (status),
// pix_valid/pix_ready/pix_data (pixel stream out), bus (AXI3 read master),
// err (sticky bus error, only when FB_READER_RRESP_CHECK_EN is defined).
module fb_reader
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter logic [7:0] ARID = 8'h00
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [31:0] base_addr,
  input logic [19:0] frame_words,
  output logic busy,
  output logic done,
  output logic pix_valid,
  input logic pix_ready,
  output logic [31:0] pix_data,
  fb_reader_if.master bus
`ifdef FB_READER_RRESP_CHECK_EN
  ,
  output logic err
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ROOM_MAX = CW'(FIFO_DEPTH - BURST_WORDS);
  state_t state;
  logic [19:0] remaining;
  logic [3:0] beat;
  logic [CW-1:0] count;
  logic beat_in;
  logic unused;
  assign beat_in = bus.rvalid & bus.rready;
  assign bus.arid = ARID;
  assign bus.arlen = AXI_LEN;
  assign bus.arsize = AXI_SIZE;
  assign bus.arburst = AXI_INCR;
  assign bus.arcache = AXI_CACHE;
  assign bus.arprot = 3'b000;
  assign bus.arlock = 2'b00;
`ifdef FB_READER_RRESP_CHECK_EN
  assign unused = ^bus.rid;
`else
  assign unused = ^{bus.rid, bus.rresp, bus.rlast};
`endif
  fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(beat_in),
    .wdata(bus.rdata),
    .pop(pix_ready),
    .rdata(pix_data),
    .valid(pix_valid),
    .count(count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      bus.arvalid <= 1'b0;
      bus.araddr <= '0;
      bus.rready <= 1'b0;
      remaining <= '0;
      beat <= '0;
`ifdef FB_READER_RRESP_CHECK_EN
      err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            bus.araddr <= base_addr;
            remaining <= frame_words;
            busy <= frame_words != '0;
            done <= frame_words == '0;
            state <= frame_words != '0 ? ADDR : IDLE;
`ifdef FB_READER_RRESP_CHECK_EN
            err <= 1'b0;
`endif
          end
        ADDR:
          // the burst's 16 FIFO slots are reserved before the request goes out
          if (bus.arvalid && bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.araddr <= bus.araddr + BURST_BYTES;
            remaining <= remaining - 20'(BURST_WORDS);
            bus.rready <= 1'b1;
            beat <= '0;
            state <= DATA;
          end else if (count <= ROOM_MAX) bus.arvalid <= 1'b1;
        DATA:
          if (beat_in) begin
            beat <= beat + 4'd1;
`ifdef FB_READER_RRESP_CHECK_EN
            if (bus.rresp != 2'b00 || bus.rlast != (beat == AXI_LEN)) err <= 1'b1;
`endif
            if (beat == AXI_LEN) begin
              bus.rready <= 1'b0;
              state <= remaining != '0 ? ADDR : IDLE;
              busy <= remaining != '0;
              done <= remaining == '0;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fb_reader.sv
// tb_fb_reader: randomized self-checking bench for fb_reader with an AXI slave model and pixel scoreboard
module tb_fb_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pix_ready = 1'b0;
  logic [31:0] base_addr = '0;
  logic [19:0] frame_words = '0;
  logic busy, done, pix_valid;
  logic [31:0] pix_data;
`ifdef FB_READER_RRESP_CHECK_EN
  logic err;
`endif
  fb_reader_if bus ();
  fb_reader #(.FIFO_DEPTH(64), .ARID(8'h5C)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .frame_words(frame_words),
    .busy(busy),
    .done(done),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .bus(bus)
`ifdef FB_READER_RRESP_CHECK_EN
    ,
    .err(err)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int ar_pct = 100, r_pct = 100, pop_pct = 100, pop_budget = -1, ar_stall = 0, err_beat = -1;
  int beats = 0, first_beat_cyc = -1, last_beat_cyc = -1, first_pop_cyc = -1;
  int const_bad = 0, ar_unstable = 0, ar_wait = 0;
  bit ar_pend = 0, r_act = 0;
  int r_idx = 0;
  logic [31:0] r_addr = '0, hold_addr = '0, salt = '0;
  logic [3:0] hold_len = '0;
  logic [31:0] ar_log[$];
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  // memory contents: an arbitrary but fixed function of the word address
  function automatic logic [31:0] data_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  function automatic int first_diff();
    if (got.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI slave + pixel consumer; handshakes decided here complete at the next rising edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      r_act = 0;
      ar_pend = 0;
      bus.rvalid = 1'b0;
      bus.arready = 1'b0;
      bus.rlast = 1'b0;
      pix_ready = 1'b0;
      continue;
    end
    bus.rvalid = r_act && (int'($urandom_range(99)) < r_pct);
    bus.rdata = data_at(r_addr + 32'(4 * r_idx));
    bus.rlast = (r_idx == 15);
    bus.rresp = (beats == err_beat) ? 2'b10 : 2'b00;
    if (bus.rvalid && bus.rready) begin
      if (first_beat_cyc < 0) first_beat_cyc = cyc + 1;
      last_beat_cyc = cyc + 1;
      beats++;
      r_idx++;
      if (r_idx == 16) r_act = 0;
    end
    if (bus.arvalid && ar_stall > 0) begin
      bus.arready = 1'b0;
      ar_stall--;
    end else bus.arready = int'($urandom_range(99)) < ar_pct;
    if (bus.arvalid) begin
      if (!ar_pend) begin
        ar_pend = 1;
        hold_addr = bus.araddr;
        hold_len = bus.arlen;
        ar_wait = 0;
      end else if (bus.araddr !== hold_addr || bus.arlen !== hold_len) ar_unstable++;
      ar_wait++;
    end
    if (bus.arvalid && bus.arready) begin
      ar_log.push_back(bus.araddr);
      if (bus.arlen !== 4'd15 || bus.arsize !== 3'b010 || bus.arburst !== 2'b01 || bus.arcache !== 4'b0011 ||
          bus.arprot !== 3'b000 || bus.arlock !== 2'b00 || bus.arid !== 8'h5C) const_bad++;
      r_act = 1;
      r_idx = 0;
      r_addr = bus.araddr;
      ar_pend = 0;
    end
    pix_ready = (pop_budget != 0) && (int'($urandom_range(99)) < pop_pct);
    if (pix_ready && pix_valid) begin
      got.push_back(pix_data);
      if (first_pop_cyc < 0) first_pop_cyc = cyc + 1;
      if (pop_budget > 0) pop_budget--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ar_log.delete();
    got.delete();
    exp_q.delete();
    beats = 0;
    first_beat_cyc = -1;
    first_pop_cyc = -1;
    const_bad = 0;
    ar_unstable = 0;
  endtask

  task automatic kick(input logic [31:0] b, input logic [19:0] w);
    base_addr = b;
    frame_words = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(w); i++) exp_q.push_back(data_at(b + 32'(4 * i)));
  endtask

  task automatic wait_done(input int lim, output bit ok, output int dcyc);
    ok = 0;
    dcyc = -1;
    for (int i = 0; i < lim; i++) begin
      if (done) begin
        ok = 1;
        dcyc = cyc;
        return;
      end
      tick();
    end
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && got.size() < exp_q.size(); i++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({busy, done, bus.arvalid, bus.rready, pix_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b want 00000", {busy, done, bus.arvalid, bus.rready, pix_valid});
    end
`ifdef FB_READER_RRESP_CHECK_EN
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err got %b want 0", err);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int dcyc;
    ar_pct = 100; r_pct = 100; pop_pct = 100; pop_budget = -1;
    clear_logs();
    kick(32'h0010_0000, 20'd32);
    wait_done(300, ok, dcyc);
    checks++;
    if (!ok) begin fails++; $display("FAIL basic_done_timeout got none want done"); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    checks++;
    if (dcyc !== last_beat_cyc || beats !== 32) begin
      fails++;
      $display("FAIL basic_done_cycle got cyc %0d beats %0d want cyc %0d beats 32", dcyc, beats, last_beat_cyc);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++;
    if (ar_log.size() !== 2 || ar_log[0] !== 32'h0010_0000 || ar_log[1] !== 32'h0010_0040) begin
      fails++;
      $display("FAIL basic_bursts got n=%0d a0=%h a1=%h want 2 00100000 00100040", ar_log.size(), ar_log[0], ar_log[1]);
    end
    checks++;
    if (const_bad !== 0) begin fails++; $display("FAIL basic_ar_constants got %0d bad want 0", const_bad); end
    drain(200);
    checks++;
    if (first_diff() !== -1) begin fails++; $display("FAIL basic_pixels got diff at %0d want -1", first_diff()); end
    checks++;
    if (first_pop_cyc !== first_beat_cyc + 1) begin
      fails++;
      $display("FAIL basic_latency got %0d want %0d", first_pop_cyc, first_beat_cyc + 1);
    end
  endtask

  task automatic test_zero();
    clear_logs();
    kick(32'h0004_0000, 20'd0);
    checks++;
    if ({done, busy, bus.arvalid} !== 3'b100) begin
      fails++;
      $display("FAIL zero_done got done/busy/arvalid=%b want 100", {done, busy, bus.arvalid});
    end
    repeat (5) tick();
    checks++;
    if (done !== 1'b0 || ar_log.size() !== 0) begin
      fails++;
      $display("FAIL zero_no_traffic got done=%b bursts=%0d want 0 0", done, ar_log.size());
    end
  endtask

  task automatic test_ar_stall();
    bit ok;
    int dcyc;
    clear_logs();
    ar_stall = 5;
    kick(32'h0003_0000, 20'd16);
    wait_done(300, ok, dcyc);
    checks++;
    if (!ok || ar_log.size() !== 1) begin
      fails++;
      $display("FAIL stall_handshake got done=%0d bursts=%0d want 1 1", ok, ar_log.size());
    end
    checks++;
    if (ar_unstable !== 0 || ar_wait !== 6) begin
      fails++;
      $display("FAIL stall_stable got changes=%0d wait=%0d want 0 6", ar_unstable, ar_wait);
    end
    drain(200);
    checks++;
    if (first_diff() !== -1) begin fails++; $display("FAIL stall_pixels got diff at %0d want -1", first_diff()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int dcyc;
    clear_logs();
    pop_budget = 0;
    kick(32'h0002_0000, 20'd256);
    repeat (200) tick();
    checks++;
    if (ar_log.size() !== 4 || beats !== 64 || bus.arvalid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL bp_full got bursts=%0d beats=%0d arvalid=%b busy=%b want 4 64 0 1", ar_log.size(), beats, bus.arvalid, busy);
    end
    pop_budget = 15;
    repeat (40) tick();
    checks++;
    if (ar_log.size() !== 4 || bus.arvalid !== 1'b0 || got.size() !== 15) begin
      fails++;
      $display("FAIL bp_15_pops got bursts=%0d arvalid=%b pops=%0d want 4 0 15", ar_log.size(), bus.arvalid, got.size());
    end
    pop_budget = 1;
    repeat (10) tick();
    checks++;
    if (ar_log.size() !== 5) begin fails++; $display("FAIL bp_16th_pop got bursts=%0d want 5", ar_log.size()); end
    pop_budget = -1;
    wait_done(3000, ok, dcyc);
    checks++;
    if (!ok) begin fails++; $display("FAIL bp_done_timeout got none want done"); end
    drain(400);
    checks++;
    if (first_diff() !== -1) begin fails++; $display("FAIL bp_pixels got diff at %0d want -1", first_diff()); end
  endtask

  task automatic test_back_to_back();
    bit ok, okq;
    int dcyc, n;
    logic [31:0] b;
    clear_logs();
    for (int f = 0; f < 6; f++) begin
      ar_pct = $urandom_range(30, 100);
      r_pct = $urandom_range(30, 100);
      pop_pct = $urandom_range(20, 100);
      b = $urandom & 32'h7FFF_FFC0;
      n = $urandom_range(1, 6);
      ar_log.delete();
      kick(b, 20'(16 * n));
      repeat (3) tick();
      base_addr = 32'h0DEA_0000;
      frame_words = 20'd16;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(4000, ok, dcyc);
      checks++;
      if (!ok) begin fails++; $display("FAIL b2b_done_timeout frame %0d got none want done", f); end
      okq = ar_log.size() == n;
      foreach (ar_log[k]) if (ar_log[k] !== b + 32'(64 * k)) okq = 0;
      checks++;
      if (!okq) begin
        fails++;
        $display("FAIL b2b_bursts frame %0d got n=%0d first=%h want n=%0d first=%h", f, ar_log.size(), ar_log[0], n, b);
      end
    end
    pop_pct = 100;
    drain(2000);
    checks++;
    if (first_diff() !== -1) begin fails++; $display("FAIL b2b_pixels got diff at %0d want -1", first_diff()); end
    checks++;
    if (const_bad !== 0) begin fails++; $display("FAIL b2b_ar_constants got %0d bad want 0", const_bad); end
    ar_pct = 100; r_pct = 100;
  endtask

  task automatic test_rresp();
    bit ok;
    int dcyc;
    clear_logs();
    err_beat = 2;
    kick(32'h0007_0000, 20'd32);
    wait_done(300, ok, dcyc);
    checks++;
    if (!ok) begin fails++; $display("FAIL rresp_done_timeout got none want done"); end
`ifdef FB_READER_RRESP_CHECK_EN
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL rresp_err_set got %b want 1", err); end
    repeat (5) tick();
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL rresp_err_sticky got %b want 1", err); end
    err_beat = -1;
    kick(32'h0007_1000, 20'd16);
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL rresp_err_clear got %b want 0", err); end
    wait_done(300, ok, dcyc);
`endif
    err_beat = -1;
    drain(200);
    checks++;
    if (first_diff() !== -1) begin fails++; $display("FAIL rresp_pixels got diff at %0d want -1", first_diff()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int dcyc;
    clear_logs();
    pop_budget = 0;
    kick(32'h0005_0000, 20'd64);
    for (int i = 0; i < 300 && beats < 22; i++) tick();
    checks++;
    if (beats < 22 || pix_valid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_setup got beats=%0d pix_valid=%b want 22 1", beats, pix_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, bus.arvalid, bus.rready, pix_valid} !== 5'b0) begin
      fails++;
      $display("FAIL rstmid_outputs got %b want 00000", {busy, done, bus.arvalid, bus.rready, pix_valid});
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    clear_logs();
    pop_budget = -1;
    kick(32'h0006_0000, 20'd32);
    wait_done(300, ok, dcyc);
    checks++;
    if (!ok) begin fails++; $display("FAIL rstmid_done_timeout got none want done"); end
    drain(200);
    checks++;
    if (first_diff() !== -1) begin fails++; $display("FAIL rstmid_pixels got diff at %0d want -1", first_diff()); end
  endtask

  initial begin
    salt = $urandom;
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rid = 8'h00;
    bus.rresp = 2'b00;
    bus.rdata = '0;
    bus.rlast = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_ar_stall();
    test_backpressure();
    test_back_to_back();
    test_rresp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, pixel FIFO depth in 32-bit words (power of 2, >= 32).
REQ-002 SHALL have parameter ARID, default 8'h00, constant AXI read ID driven on arid.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-high.
REQ-005 start  in  1  one-cycle pulse; latches base_addr and frame_words.
REQ-006 base_addr  in  32  frame start address, 64-byte aligned.
REQ-007 frame_words  in  20  frame length in 32-bit words, multiple of 16.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 done  out  1  one-cycle pulse when the last beat enters the FIFO.
REQ-010 pix_valid / pix_ready / pix_data  out/in/out  1/1/32  pixel stream toward the video timing stage.
REQ-011 arvalid, arready, arid[7:0], araddr[31:0], arlen[3:0], arsize[2:0], arburst[1:0], arcache[3:0], arprot[2:0], arlock[1:0]  out (arready in)  AXI3 read-address channel to fpga_to_hps.
REQ-012 rvalid, rready, rid[7:0], rresp[1:0], rdata[31:0], rlast  in (rready out)  AXI3 read-data channel.
REQ-013 err  out  1  sticky bus-error flag (present only with FB_READER_RRESP_CHECK_EN).

Function
REQ-014 FSM states SHALL be IDLE, ADDR, DATA.
REQ-015 IDLE: start with frame_words != 0 -> ADDR, busy=1; start with frame_words == 0 -> done pulse next cycle, no bus traffic.
REQ-016 start SHALL be ignored while busy.
REQ-017 ADDR: arvalid SHALL rise only when FIFO free space >= 16 words; araddr, arlen held stable until arready.
REQ-018 Constants: arlen=15, arsize=3'b010, arburst=2'b01 (INCR), arcache=4'b0011, arprot=0, arlock=0, arid=ARID.
REQ-019 arvalid & arready -> DATA; araddr += 64; remaining -= 16.
REQ-020 DATA: rready=1 for the whole state; each rvalid beat SHALL be written to the FIFO in the same cycle (space already reserved).
REQ-021 Internal beat counter (4 bit) SHALL end the burst at the 16th beat regardless of rlast.
REQ-022 End of burst: remaining != 0 -> ADDR; remaining == 0 -> IDLE, done=1, busy=0.
REQ-023 Only one burst outstanding at a time; bursts never cross 4 KB (64-byte aligned, 64-byte long).
REQ-024 FIFO read side: pix_valid = !empty; pop on pix_valid & pix_ready; first-word latency from write to pix_valid = 1 cycle.
REQ-025 Simultaneous push and pop on a full or empty FIFO SHALL keep count consistent (net zero).
REQ-026 FIFO SHALL continue draining after done; next frame may start while FIFO holds data.

Reset
REQ-027 rst SHALL force: state IDLE, arvalid=0, rready=0, busy=0, done=0, pix_valid=0, FIFO empty, counters 0, err=0.
REQ-028 rst mid-burst SHALL abandon the burst; remaining beats after release are not the block's responsibility.

Configuration
REQ-029 With FB_READER_RRESP_CHECK_EN defined: err set on any beat with rresp != 0, or rlast mismatch with the 16th beat; cleared only by rst or accepted start.
REQ-030 Without FB_READER_RRESP_CHECK_EN: err port absent; rresp and rlast ignored.

Structure
REQ-031 Shared package fb_pkg SHALL hold AXI constants (burst length 16, INCR, size 4 bytes, cache 0011) and FSM state enum.
REQ-032 Pixel FIFO SHALL be a sub-module fb_fifo (sync, first-word-fall-through, count output).

Verification
REQ-033 base 0x0010_0000, 32 words, arready/rvalid always high, pix_ready=1 -> two bursts at 0x0010_0000 and 0x0010_0040, done after 32nd beat, pixel order = rdata order.
REQ-034 pix_ready=0, 256 words, FIFO_DEPTH=64 -> exactly 4 bursts issued, then arvalid stays low until the consumer pops 16 words.
REQ-035 arready low for 5 cycles -> araddr/arlen stable throughout, single handshake.
REQ-036 frame_words=0 -> done one cycle after start, no arvalid.
REQ-037 rst asserted at beat 7 of burst 2 -> all outputs at reset values in the same cycle, FIFO empty.
REQ-038 Macro on: rresp=2'b10 on beat 3 -> err=1 and stays 1 until next start; macro off: frame completes, no err port.
